uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of source-side byte streams and UART-side byte handshake for
// uart_tx_arbiter. The slave modport is the arbiter's view. The master modport
// is the view of whatever drives the sources and the UART ready.
interface uart_tx_arbiter_if #(
   parameter int NUM_SRC   = 4,
   parameter int DATA_BITS = 8
);
   localparam int GW = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]           src_vld;
   logic [NUM_SRC*DATA_BITS-1:0] src_data;
   logic [NUM_SRC-1:0]           src_last;
   logic [NUM_SRC-1:0]           src_rdy;
   logic                         uart_tx_rdy;
   logic                         uart_tx_vld;
   logic [DATA_BITS-1:0]         uart_tx_data;
   logic [GW-1:0]                grant_id;
   logic                         busy;
   logic                         timeout_err;

   modport master (
      output src_vld, src_data, src_last, uart_tx_rdy,
      input  src_rdy, uart_tx_vld, uart_tx_data, grant_id, busy, timeout_err
   );

   modport slave (
      input  src_vld, src_data, src_last, uart_tx_rdy,
      output src_rdy, uart_tx_vld, uart_tx_data, grant_id, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that merges several byte streams onto a
// single UART transmitter. A granted source keeps the transmitter until its
// last byte is accepted by the UART, or until it stalls mid-packet for
// IDLE_TIMEOUT cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no grant held; pick next requester round-robin
// ARB_XFER | granted source may hand over one byte; stall timer runs
// ARB_WAIT | byte held on uart_tx_*; waiting for UART to take it
module uart_tx_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DATA_BITS    = 8,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.slave   bus
);

   localparam int GW = $clog2(NUM_SRC);
   localparam int CW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(IDLE_TIMEOUT);
   localparam logic [GW-1:0] GRANT_RST = GW'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_XFER = 2'd1,
      ARB_WAIT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        grant_id_q, grant_id_d;
   logic                 tx_vld_q, tx_vld_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic                 last_q, last_d;
   logic [CW-1:0]        stall_q, stall_d;
   logic                 timeout_err_q, timeout_err_d;

   logic                 rr_found;
   logic [GW-1:0]        rr_pick;
   logic                 sel_vld;
   logic                 sel_last;
   logic [DATA_BITS-1:0] sel_data;
   logic                 src_hs;
   logic [NUM_SRC-1:0]   src_rdy;
   logic                 busy;

   // State and datapath registers with synchronous reset; grant resets to
   // the top index so source 0 is the first to win.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         grant_id_q    <= GRANT_RST;
         tx_vld_q      <= 1'b0;
         tx_data_q     <= '0;
         last_q        <= 1'b0;
         stall_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         tx_vld_q      <= tx_vld_d;
         tx_data_q     <= tx_data_d;
         last_q        <= last_d;
         stall_q       <= stall_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Round-robin search starting just after the last grant; wraps modulo
   // NUM_SRC so non-power-of-two source counts work.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = grant_id_q;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!rr_found && bus.src_vld[(int'(grant_id_q) + k) % NUM_SRC]) begin
            rr_found = 1'b1;
            rr_pick  = GW'((int'(grant_id_q) + k) % NUM_SRC);
         end
      end
   end

   // Mux out the granted source's stream.
   always_comb begin
      sel_vld  = bus.src_vld[grant_id_q];
      sel_last = bus.src_last[grant_id_q];
      sel_data = bus.src_data[int'(grant_id_q)*DATA_BITS +: DATA_BITS];
      src_hs   = sel_vld && src_rdy[grant_id_q];
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      tx_vld_d      = tx_vld_q;
      tx_data_d     = tx_data_q;
      last_d        = last_q;
      stall_d       = stall_q;
      timeout_err_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (rr_found) begin
               grant_id_d = rr_pick;
               stall_d    = '0;
               state_d    = ARB_XFER;
            end
         end
         ARB_XFER: begin
            if (src_hs) begin
               tx_data_d = sel_data;
               last_d    = sel_last;
               tx_vld_d  = 1'b1;
               stall_d   = '0;
               state_d   = ARB_WAIT;
            end else if (!sel_vld) begin
               // The increment that reaches the limit ends the packet; the
               // error pulse lands in the following ARB_IDLE cycle.
               if (stall_q >= STALL_MAX - 1'b1) begin
                  stall_d       = STALL_MAX;
                  timeout_err_d = 1'b1;
                  state_d       = ARB_IDLE;
               end else begin
                  stall_d = stall_q + 1'b1;
               end
            end
         end
         ARB_WAIT: begin
            // Stall timer is frozen here: UART backpressure is not a stall.
            if (bus.uart_tx_rdy) begin
               tx_vld_d = 1'b0;
               if (last_q) begin
                  state_d = ARB_IDLE;
               end else begin
                  stall_d = '0;
                  state_d = ARB_XFER;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state: ready only toward the granted
   // source, and only while no byte is pending on the UART side.
   always_comb begin
      src_rdy = '0;
      if (state_q == ARB_XFER && !tx_vld_q) begin
         src_rdy[grant_id_q] = 1'b1;
      end
      busy = (state_q != ARB_IDLE);
   end

   assign bus.src_rdy      = src_rdy;
   assign bus.busy         = busy;
   assign bus.uart_tx_vld  = tx_vld_q;
   assign bus.uart_tx_data = tx_data_q;
   assign bus.grant_id     = grant_id_q;
   assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues feed the DUT,
// a monitor records every UART handshake, and each scenario task checks the
// recorded stream against hand-computed expectations.
module tb_uart_tx_arbiter;

   localparam int NUM_SRC      = 4;
   localparam int DATA_BITS    = 8;
   localparam int IDLE_TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_BITS(DATA_BITS)) bus ();

   uart_tx_arbiter #(
      .NUM_SRC      (NUM_SRC),
      .DATA_BITS    (DATA_BITS),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // {last, data} entries per source
   logic [8:0] srcq [NUM_SRC][$];
   logic [7:0] out_q [$];
   logic [1:0] gid_q [$];
   int hs_cyc  = 0;
   int to_cnt  = 0;
   int to_cyc  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // UART-side monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.uart_tx_vld && bus.uart_tx_rdy) begin
            out_q.push_back(bus.uart_tx_data);
            gid_q.push_back(bus.grant_id);
            hs_cyc = cyc;
         end
         if (bus.timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
         end
      end
   end

   // Source driver: presents queue heads, pops on an observed source handshake
   always begin : drv
      logic [NUM_SRC-1:0] hs;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (srcq[i].size() > 0) begin
            bus.src_vld[i] = 1'b1;
            bus.src_last[i] = srcq[i][0][8];
            bus.src_data[i*DATA_BITS +: DATA_BITS] = srcq[i][0][7:0];
         end else begin
            bus.src_vld[i] = 1'b0;
            bus.src_last[i] = 1'b0;
            bus.src_data[i*DATA_BITS +: DATA_BITS] = 8'h00;
         end
      end
      @(negedge clk);
      hs = bus.src_vld & bus.src_rdy;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
      out_q.delete();
      gid_q.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_all();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (out_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (out_q.size() >= n) ok = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.uart_tx_rdy = 1'b0;
      clear_all();
      step(); step(); step();
      n_vec++; if (bus.uart_tx_vld !== 1'b0) begin n_err++; $display("FAIL rst_tx_vld: got %0b expected 0", bus.uart_tx_vld); end
      n_vec++; if (bus.uart_tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %0h expected 0", bus.uart_tx_data); end
      n_vec++; if (bus.src_rdy !== 4'b0000) begin n_err++; $display("FAIL rst_src_rdy: got %0b expected 0000", bus.src_rdy); end
      n_vec++; if (bus.grant_id !== 2'd3) begin n_err++; $display("FAIL rst_grant_id: got %0d expected 3", bus.grant_id); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", bus.busy); end
      n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %0b expected 0", bus.timeout_err); end
      reset = 1'b0;
   endtask

   task automatic test_single_source();
      bit ok;
      bus.uart_tx_rdy = 1'b1;
      clear_all();
      srcq[2].push_back({1'b0, 8'h41});
      srcq[2].push_back({1'b1, 8'h42});
      step();
      n_vec++; if (bus.src_rdy !== 4'b0100) begin n_err++; $display("FAIL single_grant_latency: src_rdy got %0b expected 0100", bus.src_rdy); end
      n_vec++; if (bus.grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant_id: got %0d expected 2", bus.grant_id); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_high: got %0b expected 1", bus.busy); end
      wait_out(2, 50, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL single_wait: got %0d bytes expected 2", out_q.size()); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %0b expected 0", bus.busy); end
      n_vec++; if (out_q[0] !== 8'h41 || gid_q[0] !== 2'd2) begin n_err++; $display("FAIL single_byte0: got %0h/%0d expected 41/2", out_q[0], gid_q[0]); end
      n_vec++; if (out_q[1] !== 8'h42 || gid_q[1] !== 2'd2) begin n_err++; $display("FAIL single_byte1: got %0h/%0d expected 42/2", out_q[1], gid_q[1]); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [7:0] exp_d [6];
      logic [1:0] exp_g [6];
      exp_d = '{8'hA0, 8'hA1, 8'hA3, 8'hB0, 8'hB1, 8'hB3};
      exp_g = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      apply_reset();
      bus.uart_tx_rdy = 1'b1;
      srcq[0].push_back({1'b1, 8'hA0}); srcq[0].push_back({1'b1, 8'hB0});
      srcq[1].push_back({1'b1, 8'hA1}); srcq[1].push_back({1'b1, 8'hB1});
      srcq[3].push_back({1'b1, 8'hA3}); srcq[3].push_back({1'b1, 8'hB3});
      wait_out(6, 200, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rr_wait: got %0d bytes expected 6", out_q.size()); end
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (out_q[k] !== exp_d[k] || gid_q[k] !== exp_g[k]) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got %0h/%0d expected %0h/%0d", k, out_q[k], gid_q[k], exp_d[k], exp_g[k]);
         end
      end
   endtask

   task automatic test_packet_lock();
      bit ok;
      logic [7:0] exp_d [5];
      logic [1:0] exp_g [5];
      exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};
      exp_g = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      clear_all();
      bus.uart_tx_rdy = 1'b1;
      srcq[1].push_back({1'b0, 8'hC0});
      srcq[1].push_back({1'b0, 8'hC1});
      srcq[1].push_back({1'b0, 8'hC2});
      srcq[1].push_back({1'b1, 8'hC3});
      step();
      srcq[0].push_back({1'b1, 8'hD0});
      wait_out(5, 200, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL lock_wait: got %0d bytes expected 5", out_q.size()); end
      for (int k = 0; k < 5; k++) begin
         n_vec++;
         if (out_q[k] !== exp_d[k] || gid_q[k] !== exp_g[k]) begin
            n_err++;
            $display("FAIL lock_order[%0d]: got %0h/%0d expected %0h/%0d", k, out_q[k], gid_q[k], exp_d[k], exp_g[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad;
      int to_base;
      clear_all();
      bus.uart_tx_rdy = 1'b0;
      to_base = to_cnt;
      srcq[2].push_back({1'b1, 8'hE2});
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         step();
         if (bus.uart_tx_vld === 1'b1) ok = 1'b1;
      end
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp_vld_rise: got %0b expected 1", bus.uart_tx_vld); end
      bad = 0;
      for (int k = 0; k < 5000; k++) begin
         step();
         if (bus.uart_tx_vld !== 1'b1 || bus.uart_tx_data !== 8'hE2 || bus.src_rdy !== 4'b0000) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
      n_vec++; if (to_cnt != to_base) begin n_err++; $display("FAIL bp_no_timeout: got %0d pulses expected 0", to_cnt - to_base); end
      bus.uart_tx_rdy = 1'b1;
      wait_out(1, 20, ok);
      n_vec++; if (!ok || out_q[0] !== 8'hE2) begin n_err++; $display("FAIL bp_deliver: got %0h expected e2", out_q[0]); end
   endtask

   task automatic test_timeout();
      bit ok;
      int to_base;
      int h;
      apply_reset();
      bus.uart_tx_rdy = 1'b1;
      to_base = to_cnt;
      srcq[0].push_back({1'b0, 8'hF0});
      srcq[1].push_back({1'b1, 8'hF1});
      wait_out(1, 30, ok);
      h = hs_cyc;
      n_vec++; if (!ok || out_q[0] !== 8'hF0) begin n_err++; $display("FAIL to_first_byte: got %0h expected f0", out_q[0]); end
      for (int k = 0; k < 40 && to_cnt == to_base; k++) step();
      n_vec++; if (to_cnt != to_base + 1) begin n_err++; $display("FAIL to_pulse_count: got %0d expected 1", to_cnt - to_base); end
      n_vec++; if (to_cyc != h + 17) begin n_err++; $display("FAIL to_pulse_time: got %0d cycles after handshake expected 17", to_cyc - h); end
      wait_out(2, 30, ok);
      n_vec++; if (!ok || out_q[1] !== 8'hF1 || gid_q[1] !== 2'd1) begin n_err++; $display("FAIL to_next_grant: got %0h/%0d expected f1/1", out_q[1], gid_q[1]); end
      n_vec++; if (to_cnt != to_base + 1) begin n_err++; $display("FAIL to_single_pulse: got %0d expected 1", to_cnt - to_base); end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      clear_all();
      bus.uart_tx_rdy = 1'b0;
      srcq[2].push_back({1'b0, 8'h60});
      srcq[2].push_back({1'b1, 8'h61});
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         step();
         if (bus.uart_tx_vld === 1'b1) ok = 1'b1;
      end
      n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_wait_state: got vld %0b expected 1", bus.uart_tx_vld); end
      reset = 1'b1;
      clear_all();
      step();
      n_vec++; if (bus.uart_tx_vld !== 1'b0) begin n_err++; $display("FAIL rmid_vld_drop: got %0b expected 0", bus.uart_tx_vld); end
      n_vec++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd3) begin n_err++; $display("FAIL rmid_state: got busy %0b grant %0d expected 0/3", bus.busy, bus.grant_id); end
      step();
      reset = 1'b0;
      bus.uart_tx_rdy = 1'b1;
      srcq[3].push_back({1'b1, 8'h73});
      srcq[1].push_back({1'b1, 8'h71});
      wait_out(2, 40, ok);
      n_vec++; if (!ok || out_q[0] !== 8'h71 || gid_q[0] !== 2'd1) begin n_err++; $display("FAIL rmid_first_grant: got %0h/%0d expected 71/1", out_q[0], gid_q[0]); end
      n_vec++; if (out_q[1] !== 8'h73 || gid_q[1] !== 2'd3) begin n_err++; $display("FAIL rmid_second_grant: got %0h/%0d expected 73/3", out_q[1], gid_q[1]); end
   endtask

   initial begin
      bus.uart_tx_rdy = 1'b0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_packet_lock();
      test_backpressure();
      test_timeout();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
